// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colour, cell-code and geometry definitions for the board renderer
package vga_pkg;

    localparam logic [2:0] COL_BLACK = 3'd0;
    localparam logic [2:0] COL_WHITE = 3'd1;
    localparam logic [2:0] COL_RED   = 3'd2;
    localparam logic [2:0] COL_GREEN = 3'd3;
    localparam logic [2:0] COL_BLUE  = 3'd4;

    // Code 2'b11 is deliberately left out: it renders as an empty cell.
    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_e;

    localparam int DEF_COORD_W      = 10;
    localparam int DEF_SELECT_SIZE  = 3;
    localparam int DEF_BOARD_X0     = 140;
    localparam int DEF_BOARD_Y0     = 60;
    localparam int DEF_CELL         = 120;
    localparam int DEF_LINE_W       = 4;
    localparam int DEF_MARGIN       = 16;
    localparam int DEF_BLINK_FRAMES = 30;

endpackage

// File: rtl/vga_board_renderer_if.sv
// rtl/vga_board_renderer_if.sv - pixel timing bundle from the timing generator to the renderer
interface vga_board_renderer_if #(
    parameter int COORD_W = 10
);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               active;
    logic               hsync;
    logic               vsync;
    logic               frame_start;

    modport master (output x, y, active, hsync, vsync, frame_start);
    modport slave  (input  x, y, active, hsync, vsync, frame_start);
endinterface

// File: rtl/vga_cell_locator.sv
// rtl/vga_cell_locator.sv - one-axis board cell index and in-cell offset via range compares
module vga_cell_locator #(
    parameter int COORD_W = 10,
    parameter int ORIGIN  = 140,
    parameter int CELL    = 120
) (
    input  logic [COORD_W-1:0] coord,
    output logic [1:0]         idx,
    output logic [COORD_W-1:0] off
);
    localparam logic [COORD_W-1:0] B0 = COORD_W'(ORIGIN);
    localparam logic [COORD_W-1:0] B1 = COORD_W'(ORIGIN + CELL);
    localparam logic [COORD_W-1:0] B2 = COORD_W'(ORIGIN + 2 * CELL);
    localparam logic [COORD_W-1:0] B3 = COORD_W'(ORIGIN + 3 * CELL);

    always_comb begin
        idx = 2'd3;
        off = '0;
        if (coord >= B0 && coord < B1) begin
            idx = 2'd0;
            off = coord - B0;
        end else if (coord >= B1 && coord < B2) begin
            idx = 2'd1;
            off = coord - B1;
        end else if (coord >= B2 && coord < B3) begin
            idx = 2'd2;
            off = coord - B2;
        end
    end
endmodule

// File: rtl/vga_board_renderer.sv
// rtl/vga_board_renderer.sv - two-stage per-pixel colour select for the tic-tac-toe board
module vga_board_renderer
    import vga_pkg::*;
#(
    parameter int COORD_W      = DEF_COORD_W,
    parameter int SELECT_SIZE  = DEF_SELECT_SIZE,
    parameter int BOARD_X0     = DEF_BOARD_X0,
    parameter int BOARD_Y0     = DEF_BOARD_Y0,
    parameter int CELL         = DEF_CELL,
    parameter int LINE_W       = DEF_LINE_W,
    parameter int MARGIN       = DEF_MARGIN,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    vga_board_renderer_if.slave    tmg,
    input  logic [17:0]            board_i,
    input  logic [3:0]             cursor_i,
    input  logic [8:0]             win_mask_i,
    output logic [SELECT_SIZE-1:0] select_o,
    output logic                   active_o,
    output logic                   hsync_o,
    output logic                   vsync_o
);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [COORD_W-1:0] LW     = COORD_W'(LINE_W);
    localparam logic [COORD_W-1:0] LW2    = COORD_W'(2 * LINE_W);
    localparam logic [COORD_W-1:0] C_M1   = COORD_W'(CELL - 1);
    localparam logic [COORD_W-1:0] MG_LO  = COORD_W'(MARGIN);
    localparam logic [COORD_W-1:0] MG_HI  = COORD_W'(CELL - MARGIN);
    localparam logic [COORD_W-1:0] O_FAR  = COORD_W'(CELL - MARGIN - 1);
    localparam logic [COORD_W:0]   DIAG_C = (COORD_W+1)'(CELL - 1);

    logic [1:0]         col_c, row_c, col_q, row_q;
    logic [COORD_W-1:0] dx_c, dy_c, dx_q, dy_q;
    logic               act_q, hs_q, vs_q;
    logic [17:0]        board_sh;
    logic [3:0]         cursor_sh;
    logic [8:0]         win_sh;
    logic [BW-1:0]      blink_cnt;
    logic               blink_on;

    vga_cell_locator #(.COORD_W(COORD_W), .ORIGIN(BOARD_X0), .CELL(CELL)) u_loc_x (
        .coord(tmg.x), .idx(col_c), .off(dx_c)
    );
    vga_cell_locator #(.COORD_W(COORD_W), .ORIGIN(BOARD_Y0), .CELL(CELL)) u_loc_y (
        .coord(tmg.y), .idx(row_c), .off(dy_c)
    );

    // Game state only changes at frame boundaries so a frame never shows two boards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            board_sh  <= '0;
            cursor_sh <= 4'd15;
            win_sh    <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tmg.frame_start) begin
            board_sh  <= board_i;
            cursor_sh <= cursor_i;
            win_sh    <= win_mask_i;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= 2'd3;
            row_q <= 2'd3;
            dx_q  <= '0;
            dy_q  <= '0;
            act_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            col_q <= col_c;
            row_q <= row_c;
            dx_q  <= dx_c;
            dy_q  <= dy_c;
            act_q <= tmg.active;
            hs_q  <= tmg.hsync;
            vs_q  <= tmg.vsync;
        end
    end

    logic [3:0]         k;
    logic [1:0]         code;
    logic               win_hit, band, in_mark, x_hit, o_hit;
    logic [COORD_W-1:0] adiff;
    logic [COORD_W:0]   dsum, ddiff;
    logic [2:0]         sel;

    always_comb begin
        k       = 4'({row_q, 1'b0}) + 4'(row_q) + 4'(col_q);
        code    = 2'(board_sh >> {k, 1'b0});
        win_hit = |(win_sh & (9'd1 << k));
        band    = (dx_q >= LW && dx_q < LW2) || (dy_q >= LW && dy_q < LW2) ||
                  ((C_M1 - dx_q) >= LW && (C_M1 - dx_q) < LW2) ||
                  ((C_M1 - dy_q) >= LW && (C_M1 - dy_q) < LW2);
        in_mark = dx_q >= MG_LO && dx_q < MG_HI && dy_q >= MG_LO && dy_q < MG_HI;
        adiff   = (dx_q >= dy_q) ? dx_q - dy_q : dy_q - dx_q;
        dsum    = {1'b0, dx_q} + {1'b0, dy_q};
        ddiff   = (dsum >= DIAG_C) ? dsum - DIAG_C : DIAG_C - dsum;
        x_hit   = adiff < LW || ddiff < {1'b0, LW};
        // Subtractions below are only meaningful inside the mark region, where none underflow.
        o_hit   = (dx_q - MG_LO) < LW || (dy_q - MG_LO) < LW ||
                  (O_FAR - dx_q) < LW || (O_FAR - dy_q) < LW;

        sel = COL_BLACK;
        if (!act_q || col_q == 2'd3 || row_q == 2'd3)
            sel = COL_BLACK;
        else if ((col_q != 2'd0 && dx_q < LW) || (row_q != 2'd0 && dy_q < LW))
            sel = COL_WHITE;
        else if (k == cursor_sh && blink_on && band)
            sel = COL_GREEN;
        else if (in_mark && code == CELL_X && x_hit)
            sel = win_hit ? COL_GREEN : COL_RED;
        else if (in_mark && code == CELL_O && o_hit)
            sel = win_hit ? COL_GREEN : COL_BLUE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            select_o <= '0;
            active_o <= 1'b0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
        end else begin
            select_o <= SELECT_SIZE'(sel);
            active_o <= act_q;
            hsync_o  <= hs_q;
            vsync_o  <= vs_q;
        end
    end
endmodule

// File: tb/tb_vga_board_renderer.sv
// tb/tb_vga_board_renderer.sv - directed self-checking bench for vga_board_renderer
module tb_vga_board_renderer;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic [17:0] board_i;
    logic [3:0]  cursor_i;
    logic [8:0]  win_mask_i;
    logic [2:0]  select_o;
    logic        active_o, hsync_o, vsync_o;
    int          total = 0;
    int          bad = 0;

    vga_board_renderer_if #(.COORD_W(10)) tmg ();

    vga_board_renderer dut (
        .clk_i(clk), .rst_ni(rst_ni), .tmg(tmg),
        .board_i(board_i), .cursor_i(cursor_i), .win_mask_i(win_mask_i),
        .select_o(select_o), .active_o(active_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic act);
        @(negedge clk);
        tmg.x = 10'(x);
        tmg.y = 10'(y);
        tmg.active = act;
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        tmg.frame_start = 1'b1;
        @(negedge clk);
        tmg.frame_start = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        tmg.x = '0; tmg.y = '0; tmg.active = 1'b0;
        tmg.hsync = 1'b0; tmg.vsync = 1'b0; tmg.frame_start = 1'b0;
        board_i = 18'h00001; cursor_i = 4'd15; win_mask_i = 9'h000;
        cyc(3);
        chk("reset_select", select_o, 0);
        chk("reset_active", active_o, 0);
        chk("reset_hsync", hsync_o, 0);
        chk("reset_vsync", vsync_o, 0);
        @(negedge clk) rst_ni = 1'b1;

        // First pixel together with the first frame_start: checks latency and alignment.
        @(negedge clk);
        tmg.x = 10'd170; tmg.y = 10'd90; tmg.active = 1'b1;
        tmg.hsync = 1'b1; tmg.vsync = 1'b1; tmg.frame_start = 1'b1;
        @(posedge clk); #1;
        chk("lat1_select", select_o, 0);
        chk("lat1_hsync", hsync_o, 0);
        @(negedge clk) tmg.frame_start = 1'b0;
        @(posedge clk); #1;
        chk("x_mark_red", select_o, 2);
        chk("x_active", active_o, 1);
        chk("x_hsync", hsync_o, 1);
        chk("x_vsync", vsync_o, 1);
        @(negedge clk) begin tmg.hsync = 1'b0; tmg.vsync = 1'b0; end

        win_mask_i = 9'h001;
        pulse_fs(); cyc(2);
        chk("x_win_green", select_o, 3);
        @(negedge clk) board_i = 18'h00000;
        cyc(3);
        chk("no_tearing", select_o, 3);
        pulse_fs(); cyc(2);
        chk("empty_after_fs", select_o, 0);

        board_i = 18'h00021; win_mask_i = 9'h000;
        pulse_fs(); cyc(2);
        chk("x_again_red", select_o, 2);
        pix(260, 100, 1); cyc(2);
        chk("grid_vert", select_o, 1);
        pix(100, 100, 1); cyc(2);
        chk("left_of_board", select_o, 0);
        pix(260, 100, 0); cyc(2);
        chk("inactive_select", select_o, 0);
        chk("inactive_active", active_o, 0);
        pix(397, 100, 1); cyc(2);
        chk("o_stroke_blue", select_o, 4);
        pix(420, 120, 1); cyc(2);
        chk("o_interior", select_o, 0);
        pix(499, 180, 1); cyc(2);
        chk("right_edge_in", select_o, 1);
        pix(500, 180, 1); cyc(2);
        chk("right_edge_out", select_o, 0);

        board_i = 18'h00023;
        pulse_fs();
        pix(170, 90, 1); cyc(2);
        chk("code11_empty", select_o, 0);

        // Six frame_starts so far; blink toggles on the 30th and 60th.
        cursor_i = 4'd4;
        pulse_fs();
        pix(300, 185, 1); cyc(2);
        chk("cursor_on", select_o, 3);
        repeat (30) pulse_fs();
        cyc(2);
        chk("cursor_blink_off", select_o, 0);
        repeat (30) pulse_fs();
        cyc(2);
        chk("cursor_blink_on", select_o, 3);
        cursor_i = 4'd9;
        pulse_fs(); cyc(2);
        chk("cursor_none", select_o, 0);

        board_i = 18'h00001; cursor_i = 4'd15;
        pulse_fs();
        @(negedge clk) begin
            tmg.x = 10'd170; tmg.y = 10'd90; tmg.active = 1'b1; tmg.hsync = 1'b1;
        end
        cyc(2);
        chk("pre_reset_red", select_o, 2);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_select", select_o, 0);
        chk("async_rst_active", active_o, 0);
        chk("async_rst_hsync", hsync_o, 0);
        @(negedge clk) rst_ni = 1'b1;
        cyc(3);
        chk("post_rst_empty", select_o, 0);
        chk("post_rst_active", active_o, 1);
        pulse_fs(); cyc(2);
        chk("post_rst_fs_red", select_o, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
